// File: rtl/spi_3wire_slave.sv
// 3-wire SPI responder (mode 3, MSB first) with a 2**ADDR_W x 8 register file.
// The register file is shared between the SPI side and a local fabric port.
// Command byte is {RW, MB, A[5:0]}; MB enables address auto-increment.
`timescale 1ns/1ps
module spi_3wire_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    inout  wire               spi_sdio,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_write,
    input  logic [7:0]        loc_writedata,
    output logic [7:0]        loc_readdata,
    output logic              spi_wr_strobe,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdio_sync;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, sdio_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    logic [2:0]        bit_cnt;
    logic [6:0]        rx_shift;
    logic [7:0]        cmd_byte;
    logic [7:0]        tx_shift;
    logic [ADDR_W-1:0] ptr, ptr_inc;
    logic              mb;
    logic              sdo, sdo_en;
    logic              last_bit;
    logic              cmd_end, wr_commit, rd_end, rd_shift;

    logic [7:0] regs [DEPTH];

    // Synchronizer chains plus one extra flop on CS_n/SCLK for edge detection.
    // Reset parks CS_n and SCLK at their idle-high level so no edge is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            sdio_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], spi_sdio};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdio_s    = sdio_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign busy      = ~cs_s;

    // The byte completed on this rise: seven bits already shifted plus the current sample.
    assign cmd_byte = {rx_shift, sdio_s};
    assign ptr_inc  = ptr + ADDR_W'(1);
    assign last_bit = (bit_cnt == 3'd7);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-clk byte-boundary events; CS_n high overrides everything.
    always_comb begin
        state_next = state;
        cmd_end    = 1'b0;
        wr_commit  = 1'b0;
        rd_end     = 1'b0;
        rd_shift   = 1'b0;
        if (cs_s) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) state_next = S_CMD;
                S_CMD: begin
                    if (sclk_rise && last_bit) begin
                        cmd_end    = 1'b1;
                        state_next = cmd_byte[7] ? S_RD : S_WR;
                    end
                end
                S_WR: begin
                    if (sclk_rise && last_bit) begin
                        wr_commit = 1'b1;
                        if (!mb) state_next = S_DONE;
                    end
                end
                S_RD: begin
                    rd_shift = sclk_fall;
                    if (sclk_rise && last_bit) begin
                        rd_end = 1'b1;
                        if (!mb) state_next = S_DONE;
                    end
                end
                S_DONE: state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Serial datapath: bit counter, shift registers, address pointer and SDIO driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'd0;
            ptr           <= '0;
            mb            <= 1'b0;
            sdo           <= 1'b0;
            sdo_en        <= 1'b0;
            spi_wr_strobe <= 1'b0;
            spi_wr_addr   <= '0;
        end else begin
            spi_wr_strobe <= wr_commit;
            if (wr_commit) spi_wr_addr <= ptr;

            if (cs_s || state == S_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise && (state == S_CMD || state == S_WR || state == S_RD)) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= cmd_byte[6:0];
            end

            if (cmd_end) begin
                mb  <= cmd_byte[6];
                ptr <= cmd_byte[ADDR_W-1:0];
            end else if ((wr_commit || rd_end) && mb) begin
                ptr <= ptr_inc;
            end

            // Read data is snapshotted from the register file at the load clk only.
            if (cmd_end && cmd_byte[7]) begin
                tx_shift <= regs[cmd_byte[ADDR_W-1:0]];
            end else if (rd_end && mb) begin
                tx_shift <= regs[ptr_inc];
            end else if (rd_shift && state_next == S_RD) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (rd_shift && state_next == S_RD) begin
                sdo    <= tx_shift[7];
                sdo_en <= 1'b1;
            end else if (state_next != S_RD) begin
                sdo_en <= 1'b0;
            end
        end
    end

    assign spi_sdio = sdo_en ? sdo : 1'bz;

    // Register file: the local write is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            if (wr_commit) regs[ptr] <= cmd_byte;
            if (loc_write) regs[loc_addr] <= loc_writedata;
        end
    end

    // Local read port, one clk latency.
    always_ff @(posedge clk) begin
        if (reset) loc_readdata <= 8'h00;
        else       loc_readdata <= regs[loc_addr];
    end

endmodule

// File: tb/tb_spi_3wire_slave.sv
// Self-checking bench for spi_3wire_slave: a transaction-level register model,
// a per-clk compare process for the idle-time outputs, directed cases and a random mix.
`timescale 1ns/1ps
module tb_spi_3wire_slave;

    localparam int H = 5;   // SCLK half period in clk cycles (SCLK = clk/10)

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n, sclk;
    logic       m_oe, m_do;
    logic [5:0] loc_addr;
    logic       loc_write;
    logic [7:0] loc_wd;
    wire  [7:0] loc_rd;
    wire        strobe;
    wire  [5:0] wr_addr;
    wire        busy;
    wire        sdio;

    assign sdio = m_oe ? m_do : 1'bz;
    pullup (sdio);

    always #5 clk = ~clk;

    spi_3wire_slave #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_cs_n      (cs_n),
        .spi_sclk      (sclk),
        .spi_sdio      (sdio),
        .loc_addr      (loc_addr),
        .loc_write     (loc_write),
        .loc_writedata (loc_wd),
        .loc_readdata  (loc_rd),
        .spi_wr_strobe (strobe),
        .spi_wr_addr   (wr_addr),
        .busy          (busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mreg [64];
    logic [7:0] exp_rd = 8'h00;
    bit         chk_en = 1'b0;
    logic [5:0] strobe_q [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model of the local port: read returns the pre-write contents, write lands at the edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_rd = 8'h00;
            for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
        end else begin
            exp_rd = mreg[loc_addr];
            if (loc_write) mreg[loc_addr] = loc_wd;
        end
    end

    // Compare process: while the SPI bus is idle, every output is fully determined by the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("loc_readdata", 32'(loc_rd), 32'(exp_rd));
            check("busy_idle", 32'(busy), 32'd0);
            check("strobe_idle", 32'(strobe), 32'd0);
            check("sdio_released", 32'(sdio), 32'd1);
        end
    end

    // Record every SPI write commit.
    always @(negedge clk) begin
        if (strobe) strobe_q.push_back(wr_addr);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        clks(2);
        chk_en = 1'b1;
    endtask

    task automatic loc_wr(input logic [5:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wd    = d;
        loc_write = 1'b1;
        clks(1);
        loc_write = 1'b0;
    endtask

    task automatic loc_rdback(input logic [5:0] a, output logic [7:0] d);
        loc_addr = a;
        clks(1);
        @(negedge clk);
        d = loc_rd;
    endtask

    task automatic spi_begin();
        chk_en = 1'b0;
        strobe_q.delete();
        cs_n = 1'b0;
        clks(6);
        check("busy_active", 32'(busy), 32'd1);
    endtask

    task automatic spi_end();
        cs_n = 1'b1;
        m_oe = 1'b0;
        clks(6);
    endtask

    // Master drives on the fall, slave samples on the rise. Optionally fires a local
    // write at the clk where the slave registers the 8th rise (sync depth + edge flop).
    task automatic send_bits(input logic [7:0] b, input int n, input bit col_en,
                             input logic [5:0] col_a, input logic [7:0] col_d);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            m_oe = 1'b1;
            m_do = b[7-i];
            clks(H);
            sclk = 1'b1;
            if (col_en && i == 7) begin
                clks(2);
                loc_addr  = col_a;
                loc_wd    = col_d;
                loc_write = 1'b1;
                clks(1);
                loc_write = 1'b0;
                clks(H - 3);
            end else begin
                clks(H);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8, 1'b0, 6'd0, 8'd0);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            m_oe = 1'b0;
            clks(H);
            b[7-i] = sdio;
            sclk = 1'b1;
            clks(H);
        end
    endtask

    task automatic spi_write(input logic [5:0] a, input logic mb, input int n, input logic [31:0] dw);
        int         ncommit;
        logic [5:0] ea;
        spi_begin();
        send_byte({1'b0, mb, a});
        for (int i = 0; i < n; i++) send_byte(dw[31-8*i -: 8]);
        spi_end();
        ncommit = mb ? n : 1;
        check("wr_strobe_count", strobe_q.size(), 32'(ncommit));
        for (int i = 0; i < ncommit; i++) begin
            ea = a + 6'(i);
            if (i < strobe_q.size()) check("wr_strobe_addr", 32'(strobe_q[i]), 32'(ea));
            mreg[ea] = dw[31-8*i -: 8];
        end
        settle();
    endtask

    task automatic spi_read(input logic [5:0] a, input logic mb, input int n, output logic [31:0] got);
        logic [7:0] b, e;
        logic [5:0] ea;
        got = 32'd0;
        spi_begin();
        send_byte({1'b1, mb, a});
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            got[31-8*i -: 8] = b;
            ea = a + 6'(i);
            e  = (mb || i == 0) ? mreg[ea] : 8'hFF;
            check("spi_rd_byte", 32'(b), 32'(e));
        end
        spi_end();
        check("rd_no_strobe", strobe_q.size(), 32'd0);
        check("sdio_after_read", 32'(sdio), 32'd1);
        settle();
    endtask

    initial begin
        logic [7:0]  d;
        logic [31:0] got;
        logic [5:0]  a;
        logic        mb;
        int          n, op;

        reset = 1'b1; cs_n = 1'b1; sclk = 1'b1; m_oe = 1'b0; m_do = 1'b0;
        loc_addr = 6'd0; loc_write = 1'b0; loc_wd = 8'd0;
        clks(2);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_loc_readdata", 32'(loc_rd), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sdio", 32'(sdio), 32'd1);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        loc_rdback(6'h3F, d);
        check("rst_reg3f", 32'(d), 32'h00);
        settle();

        // Single write
        spi_write(6'h05, 1'b0, 1, {8'hA7, 24'h0});
        check("single_wr_addr", 32'(wr_addr), 32'h05);
        loc_rdback(6'h05, d);
        check("single_wr_data", 32'(d), 32'hA7);

        // Multi-byte write across the top of the map
        spi_write(6'h3E, 1'b1, 3, {8'h11, 8'h22, 8'h33, 8'h00});
        check("wrap_strobes", strobe_q.size(), 32'd3);
        loc_rdback(6'h3E, d); check("wrap_reg3e", 32'(d), 32'h11);
        loc_rdback(6'h3F, d); check("wrap_reg3f", 32'(d), 32'h22);
        loc_rdback(6'h00, d); check("wrap_reg00", 32'(d), 32'h33);
        settle();

        // Single read, then 8 extra SCLKs in DONE read back the pullup
        loc_wr(6'h12, 8'h5C);
        spi_read(6'h12, 1'b0, 2, got);
        check("read_5c", 32'(got[31:24]), 32'h5C);
        check("read_done_hiz", 32'(got[23:16]), 32'hFF);

        // Multi-byte read
        loc_wr(6'h20, 8'hC3);
        loc_wr(6'h21, 8'h3C);
        spi_read(6'h20, 1'b1, 2, got);
        check("mread", 32'(got[31:16]), 32'hC33C);

        // Write aborted after 5 data bits
        loc_wr(6'h08, 8'h3D);
        spi_begin();
        send_byte(8'h08);
        send_bits(8'hAB, 5, 1'b0, 6'd0, 8'd0);
        spi_end();
        check("abort_no_strobe", strobe_q.size(), 32'd0);
        loc_rdback(6'h08, d);
        check("abort_reg08", 32'(d), 32'h3D);
        settle();

        // Same-clk SPI commit and local write to the same address
        spi_begin();
        send_byte(8'h09);
        send_bits(8'h42, 8, 1'b1, 6'h09, 8'hFF);
        spi_end();
        check("coll_strobe_count", strobe_q.size(), 32'd1);
        if (strobe_q.size() > 0) check("coll_strobe_addr", 32'(strobe_q[0]), 32'h09);
        loc_rdback(6'h09, d);
        check("coll_local_wins", 32'(d), 32'hFF);
        settle();

        // Same-clk SPI commit and local write to different addresses
        spi_begin();
        send_byte(8'h0B);
        send_bits(8'h6E, 8, 1'b1, 6'h0A, 8'h81);
        spi_end();
        check("coll2_strobe_count", strobe_q.size(), 32'd1);
        mreg[6'h0B] = 8'h6E;
        loc_rdback(6'h0A, d); check("coll2_local", 32'(d), 32'h81);
        loc_rdback(6'h0B, d); check("coll2_spi", 32'(d), 32'h6E);
        settle();

        // Random mix of local and SPI traffic against the model
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            a  = 6'($urandom_range(0, 63));
            mb = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            case (op)
                0: begin
                    d = 8'($urandom);
                    loc_wr(a, d);
                    loc_rdback(a, got[7:0]);
                    check("rand_loc_wr", 32'(got[7:0]), 32'(d));
                end
                1: spi_write(a, mb, n, $urandom);
                2: spi_read(a, mb, (n > 3) ? 3 : n, got);
                default: begin
                    for (int k = 0; k < 8; k++) begin
                        loc_addr = 6'($urandom_range(0, 63));
                        clks(1);
                    end
                end
            endcase
        end

        clks(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
